// File: rtl/rbm_input_sampler_pkg.sv
// Shared definitions for the RBM input sampler and the hidden-layer benches.
package rbm_input_sampler_pkg;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2
  } sampler_state_e;

  // Fibonacci taps x^8+x^6+x^5+x^4+1 map to register bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS    = 8'hB8;
  localparam logic [7:0] DEFAULT_SEED = 8'd32;

  // One left shift with the tap parity fed into bit 0.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/rbm_lfsr.sv
// 8-bit Fibonacci LFSR random source; an all-zero seed would lock up, so it is replaced by 1.
module rbm_lfsr
  import rbm_input_sampler_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] seed_i,
  input  logic       en_i,
  output logic [7:0] lfsr_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Next value is only committed when enabled.
  always_comb begin
    lfsr_d = lfsr_step(lfsr_q);
  end

  // Synchronous reload of the seed, otherwise advance on enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= (seed_i == 8'd0) ? 8'd1 : seed_i;
    end else if (en_i) begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/rbm_input_sampler.sv
// Serial pixel binariser feeding the RBM hidden layer.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   LOAD    | accepting pixels, writing one bit of InputData per transfer
//   HOLD    | frame complete, InputData frozen, waiting for layer_finish
//   RELEASE | one-cycle layer_reset / frame_done pulse, then back to LOAD
module rbm_input_sampler
  import rbm_input_sampler_pkg::*;
#(
  parameter int                           general_input_dim = 15,
  parameter int                           sigmoid_bitlength = 8,
  parameter logic [7:0]                   SeedData          = DEFAULT_SEED,
  parameter logic [sigmoid_bitlength-1:0] Threshold         = 8'd128
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         mode,
  input  logic                         pixel_valid,
  input  logic [sigmoid_bitlength-1:0] PixelData,
  output logic                         pixel_ready,
  output logic [general_input_dim-1:0] InputData,
  output logic                         data_valid,
  input  logic                         layer_finish,
  output logic                         layer_reset,
  output logic                         frame_done
);

  localparam int IDX_W = (general_input_dim > 1) ? $clog2(general_input_dim) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(general_input_dim - 1);

  sampler_state_e               state_q;
  logic [IDX_W-1:0]             idx_q;
  logic [general_input_dim-1:0] data_q;
  logic                         ready_q;
  logic                         valid_q;
  logic                         lreset_q;
  logic                         done_q;

  logic                         xfer;
  logic [7:0]                   lfsr_val;
  logic [sigmoid_bitlength-1:0] cmp;
  logic                         pixel_bit;

  // Transfer qualification and binarisation of the presented pixel.
  always_comb begin
    xfer      = pixel_valid && ready_q;
    cmp       = mode ? Threshold : sigmoid_bitlength'(lfsr_val);
    pixel_bit = (PixelData > cmp);
  end

  // Random source advances only when a stochastic sample consumed its current value.
  rbm_lfsr u_lfsr (
    .clk_i  (clock),
    .rst_i  (reset),
    .seed_i (SeedData),
    .en_i   (xfer && !mode),
    .lfsr_o (lfsr_val)
  );

  // Frame sequencer with registered handshake and pulse outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_LOAD;
      idx_q    <= '0;
      data_q   <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      lreset_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (xfer) begin
            data_q[idx_q] <= pixel_bit;
            if (idx_q == LAST_IDX) begin
              idx_q   <= '0;
              state_q <= ST_HOLD;
              ready_q <= 1'b0;
              valid_q <= 1'b1;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (layer_finish) begin
            state_q  <= ST_RELEASE;
            valid_q  <= 1'b0;
            lreset_q <= 1'b1;
            done_q   <= 1'b1;
          end
        end
        ST_RELEASE: begin
          state_q  <= ST_LOAD;
          ready_q  <= 1'b1;
          lreset_q <= 1'b0;
          done_q   <= 1'b0;
        end
        default: begin
          state_q  <= ST_LOAD;
          idx_q    <= '0;
          ready_q  <= 1'b1;
          valid_q  <= 1'b0;
          lreset_q <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign pixel_ready = ready_q;
  assign InputData   = data_q;
  assign data_valid  = valid_q;
  assign layer_reset = lreset_q;
  assign frame_done  = done_q;

endmodule
